midi_voice_allocator: RTL and testbench

- Sits directly downstream of the UART MIDI message decoder and consumes its one-cycle note events (note, velocity, channel, note-on flag, ready pulse).
- Maps incoming note-on/note-off events onto a fixed pool of polyphonic voice slots.
- Presents per-voice note/velocity/channel/active state to the synthesis stage.
- When the pool is full, steals the oldest voice.

---
 rtl/midi_pkg.sv | 41 ++++
 rtl/midi_voice_allocator_voice_select.sv | 58 +++++
 rtl/midi_voice_allocator.sv | 245 ++++++++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
`timescale 1ns/1ps
// midi_pkg: shared widths, event/voice payload types and FSM encoding for
// the MIDI voice allocator.
package midi_pkg;

  localparam int unsigned NOTE_W    = 8;
  localparam int unsigned VEL_W     = 8;
  localparam int unsigned CH_W      = 4;
  // Storage width of the age field; the allocator saturates at its own
  // AGE_W parameter, which must not exceed this.
  localparam int unsigned AGE_MAX_W = 16;

  // One decoded MIDI note event, already classified as on/off.
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [VEL_W-1:0]  velocity;
    logic [CH_W-1:0]   channel;
    logic              on;
  } midi_event_t;

  // One polyphonic voice slot.
  typedef struct packed {
    logic                 active;
    logic [NOTE_W-1:0]    note;
    logic [VEL_W-1:0]     velocity;
    logic [CH_W-1:0]      channel;
    logic [AGE_MAX_W-1:0] age;
  } voice_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MATCH  = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

  // A note-on carrying velocity 0 is a note-off by MIDI convention.
  function automatic logic is_note_on(input logic status, input logic [VEL_W-1:0] vel);
    return status && (vel != '0);
  endfunction

endpackage

// File: rtl/midi_voice_allocator_voice_select.sv
`timescale 1ns/1ps
// voice_select: combinational search over the voice table.
//   i_active/i_notes/i_channels/i_ages : packed per-slot table state
//   i_note/i_channel                   : key to look up
//   o_hit_c/o_hit_idx_c                : active slot matching key (lowest index)
//   o_free_c/o_free_idx_c              : lowest inactive slot
//   o_oldest_idx_c                     : slot with max age, ties to lowest index
module voice_select
  import midi_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned SLOT_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]           i_active,
  input  logic [NOTE_W*NUM_VOICES-1:0]    i_notes,
  input  logic [CH_W*NUM_VOICES-1:0]      i_channels,
  input  logic [AGE_MAX_W*NUM_VOICES-1:0] i_ages,
  input  logic [NOTE_W-1:0]               i_note,
  input  logic [CH_W-1:0]                 i_channel,
  output logic                            o_hit_c,
  output logic [SLOT_W-1:0]               o_hit_idx_c,
  output logic                            o_free_c,
  output logic [SLOT_W-1:0]               o_free_idx_c,
  output logic [SLOT_W-1:0]               o_oldest_idx_c
);

  logic [AGE_MAX_W-1:0] w_oldest_age;

  // Descending scan so the last assignment wins with the lowest index;
  // ascending strict-greater scan keeps the lowest index on age ties.
  always_comb begin
    o_hit_c        = 1'b0;
    o_hit_idx_c    = '0;
    o_free_c       = 1'b0;
    o_free_idx_c   = '0;
    o_oldest_idx_c = '0;
    w_oldest_age   = i_ages[AGE_MAX_W-1:0];
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (i_active[i] &&
          (i_notes[i*NOTE_W +: NOTE_W] == i_note) &&
          (i_channels[i*CH_W +: CH_W] == i_channel)) begin
        o_hit_c     = 1'b1;
        o_hit_idx_c = SLOT_W'(i);
      end
      if (!i_active[i]) begin
        o_free_c     = 1'b1;
        o_free_idx_c = SLOT_W'(i);
      end
    end
    for (int i = 1; i < int'(NUM_VOICES); i++) begin
      if (i_ages[i*AGE_MAX_W +: AGE_MAX_W] > w_oldest_age) begin
        w_oldest_age   = i_ages[i*AGE_MAX_W +: AGE_MAX_W];
        o_oldest_idx_c = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_allocator.sv
`timescale 1ns/1ps
// midi_voice_allocator: maps decoded MIDI note-on/off events onto a pool of
// NUM_VOICES voice slots, stealing the oldest voice when the pool is full.
// Each event goes IDLE -> MATCH -> COMMIT; one further event may wait in a
// 1-deep pending register while the FSM is busy.
//   clk_in, rst_n_in         : clock, async active-low reset
//   note_in .. data_valid_in : one-cycle event from the MIDI decoder
//   voice_*_out              : per-slot table state, packed slot i at index i
//   voice_update_out         : pulse after any table change, update_slot_out = slot
//   stolen_out               : pulse with update when the oldest voice was reused
//   dropped_out              : pulse when an event was lost (pending full)
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic [NOTE_W-1:0]              note_in,
  input  logic [VEL_W-1:0]               velocity_in,
  input  logic [CH_W-1:0]                channel_in,
  input  logic                           status_in,
  input  logic                           data_valid_in,
  output logic [NUM_VOICES-1:0]          voice_active_out,
  output logic [NOTE_W*NUM_VOICES-1:0]   voice_note_out,
  output logic [VEL_W*NUM_VOICES-1:0]    voice_velocity_out,
  output logic [CH_W*NUM_VOICES-1:0]     voice_channel_out,
  output logic                           voice_update_out,
  output logic [$clog2(NUM_VOICES)-1:0]  update_slot_out,
  output logic                           stolen_out,
  output logic                           dropped_out
);

  localparam int unsigned SLOT_W = $clog2(NUM_VOICES);
  localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((32'd1 << AGE_W) - 32'd1);

  fsm_state_t  r_state;
  fsm_state_t  w_state_nxt;

  midi_event_t w_in_evt;
  midi_event_t r_pend;
  logic        r_pend_full;
  midi_event_t r_evt;

  voice_t      r_voices [NUM_VOICES];

  logic              r_hit;
  logic [SLOT_W-1:0] r_hit_idx;
  logic              r_free;
  logic [SLOT_W-1:0] r_free_idx;
  logic [SLOT_W-1:0] r_old_idx;

  logic              w_hit;
  logic [SLOT_W-1:0] w_hit_idx;
  logic              w_free;
  logic [SLOT_W-1:0] w_free_idx;
  logic [SLOT_W-1:0] w_old_idx;
  logic [AGE_MAX_W*NUM_VOICES-1:0] w_ages;

  logic              w_latch_pend;
  logic              w_latch_in;
  logic              w_pend_wr;
  logic              w_drop;
  logic              w_do_on;
  logic              w_do_off;
  logic              w_change;
  logic              w_steal;
  logic [SLOT_W-1:0] w_tgt;

  logic              r_update;
  logic [SLOT_W-1:0] r_update_slot;
  logic              r_stolen;
  logic              r_dropped;

  // Incoming event, classified once at the input.
  always_comb begin
    w_in_evt          = '0;
    w_in_evt.note     = note_in;
    w_in_evt.velocity = velocity_in;
    w_in_evt.channel  = channel_in;
    w_in_evt.on       = is_note_on(status_in, velocity_in);
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_latch_pend = 1'b0;
    w_latch_in   = 1'b0;
    w_do_on      = 1'b0;
    w_do_off     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_full) begin
          w_latch_pend = 1'b1;
          w_state_nxt  = MATCH;
        end else if (data_valid_in) begin
          w_latch_in   = 1'b1;
          w_state_nxt  = MATCH;
        end
      end
      MATCH:  w_state_nxt = COMMIT;
      COMMIT: begin
        w_do_on     = r_evt.on;
        w_do_off    = !r_evt.on && r_hit;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Pending slot is free if empty or being drained this very cycle.
    w_pend_wr = data_valid_in && !w_latch_in && (!r_pend_full || w_latch_pend);
    w_drop    = data_valid_in && !w_latch_in && r_pend_full && !w_latch_pend;
    w_change  = w_do_on || w_do_off;
    w_steal   = w_do_on && !r_hit && !r_free;
    if (r_hit)       w_tgt = r_hit_idx;
    else if (r_free) w_tgt = r_free_idx;
    else             w_tgt = r_old_idx;
  end

  // Pending register and the event under processing.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_evt       <= '0;
    end else begin
      if (w_pend_wr) begin
        r_pend      <= w_in_evt;
        r_pend_full <= 1'b1;
      end else if (w_latch_pend) begin
        r_pend_full <= 1'b0;
      end
      if (w_latch_pend)    r_evt <= r_pend;
      else if (w_latch_in) r_evt <= w_in_evt;
    end
  end

  // Table search feeding the MATCH registers.
  always_comb begin
    w_ages = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      w_ages[i*AGE_MAX_W +: AGE_MAX_W] = r_voices[i].age;
    end
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .SLOT_W     (SLOT_W)
  ) u_voice_select (
    .i_active       (voice_active_out),
    .i_notes        (voice_note_out),
    .i_channels     (voice_channel_out),
    .i_ages         (w_ages),
    .i_note         (r_evt.note),
    .i_channel      (r_evt.channel),
    .o_hit_c        (w_hit),
    .o_hit_idx_c    (w_hit_idx),
    .o_free_c       (w_free),
    .o_free_idx_c   (w_free_idx),
    .o_oldest_idx_c (w_old_idx)
  );

  // MATCH result registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_free     <= 1'b0;
      r_free_idx <= '0;
      r_old_idx  <= '0;
    end else if (r_state == MATCH) begin
      r_hit      <= w_hit;
      r_hit_idx  <= w_hit_idx;
      r_free     <= w_free;
      r_free_idx <= w_free_idx;
      r_old_idx  <= w_old_idx;
    end
  end

  // Voice table: target slot is written, other active slots age on note-on.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) r_voices[i] <= '0;
    end else if (w_change) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        if (SLOT_W'(i) == w_tgt) begin
          if (w_do_off) begin
            r_voices[i].active   <= 1'b0;
            r_voices[i].velocity <= '0;
            r_voices[i].age      <= '0;
          end else begin
            r_voices[i].active   <= 1'b1;
            r_voices[i].note     <= r_evt.note;
            r_voices[i].velocity <= r_evt.velocity;
            r_voices[i].channel  <= r_evt.channel;
            r_voices[i].age      <= '0;
          end
        end else if (w_do_on && r_voices[i].active && (r_voices[i].age != AGE_SAT)) begin
          r_voices[i].age <= r_voices[i].age + 1'b1;
        end
      end
    end
  end

  // Status pulses, registered so they align with the table outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_update      <= 1'b0;
      r_update_slot <= '0;
      r_stolen      <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_update  <= w_change;
      r_stolen  <= w_steal;
      r_dropped <= w_drop;
      if (w_change) r_update_slot <= w_tgt;
    end
  end

  // Repack the table flops onto the flat output buses.
  always_comb begin
    voice_active_out   = '0;
    voice_note_out     = '0;
    voice_velocity_out = '0;
    voice_channel_out  = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_active_out[i]                    = r_voices[i].active;
      voice_note_out[i*NOTE_W +: NOTE_W]     = r_voices[i].note;
      voice_velocity_out[i*VEL_W +: VEL_W]   = r_voices[i].velocity;
      voice_channel_out[i*CH_W +: CH_W]      = r_voices[i].channel;
    end
  end

  assign voice_update_out = r_update;
  assign update_slot_out  = r_update_slot;
  assign stolen_out       = r_stolen;
  assign dropped_out      = r_dropped;

endmodule

// File: tb/tb_midi_voice_allocator.sv
`timescale 1ns/1ps
// Directed bench for midi_voice_allocator (NUM_VOICES=8, AGE_W=8).
module tb_midi_voice_allocator;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [7:0]  note_in;
  logic [7:0]  velocity_in;
  logic [3:0]  channel_in;
  logic        status_in;
  logic        data_valid_in;
  logic [7:0]  voice_active_out;
  logic [63:0] voice_note_out;
  logic [63:0] voice_velocity_out;
  logic [31:0] voice_channel_out;
  logic        voice_update_out;
  logic [2:0]  update_slot_out;
  logic        stolen_out;
  logic        dropped_out;

  int n_checks = 0;
  int n_errors = 0;

  midi_voice_allocator #(.NUM_VOICES(8), .AGE_W(8)) dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .note_in            (note_in),
    .velocity_in        (velocity_in),
    .channel_in         (channel_in),
    .status_in          (status_in),
    .data_valid_in      (data_valid_in),
    .voice_active_out   (voice_active_out),
    .voice_note_out     (voice_note_out),
    .voice_velocity_out (voice_velocity_out),
    .voice_channel_out  (voice_channel_out),
    .voice_update_out   (voice_update_out),
    .update_slot_out    (update_slot_out),
    .stolen_out         (stolen_out),
    .dropped_out        (dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n_in      = 1'b0;
    data_valid_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // Drive one event for one clock; returns 1ns after the capturing edge.
  task automatic send(input logic [7:0] n, input logic [7:0] v, input logic [3:0] c, input logic s);
    @(negedge clk_in);
    note_in       = n;
    velocity_in   = v;
    channel_in    = c;
    status_in     = s;
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
  endtask

  // Advance to 1ns after the third edge counted from the event capture.
  task automatic to_result();
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  initial begin
    note_in = '0; velocity_in = '0; channel_in = '0; status_in = 1'b0;
    data_valid_in = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_active", 32'(voice_active_out), 32'h0);
    chk("rst_update", 32'(voice_update_out), 32'h0);
    chk("rst_note",   voice_note_out[31:0],  32'h0);
    chk("rst_drop",   32'(dropped_out),      32'h0);

    // Reset asserted while the event is in COMMIT
    send(8'd60, 8'd100, 4'd0, 1'b1);
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    #1;
    chk("midrst_active", 32'(voice_active_out), 32'h0);
    chk("midrst_update", 32'(voice_update_out), 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_rel_active", 32'(voice_active_out), 32'h0);
    chk("midrst_rel_update", 32'(voice_update_out), 32'h0);
    @(posedge clk_in); #1;
    chk("midrst_rel_update2", 32'(voice_update_out), 32'h0);

    // Two note-ons fill slots 0 and 1
    do_reset();
    send(8'd60, 8'd100, 4'd0, 1'b1);
    @(posedge clk_in); #1;
    chk("on1_early_update", 32'(voice_update_out), 32'h0);
    @(posedge clk_in); #1;
    chk("on1_update", 32'(voice_update_out), 32'h1);
    chk("on1_slot",   32'(update_slot_out),  32'd0);
    chk("on1_active", 32'(voice_active_out), 32'h01);
    chk("on1_note",   32'(voice_note_out[7:0]),     32'd60);
    chk("on1_vel",    32'(voice_velocity_out[7:0]), 32'd100);
    chk("on1_stolen", 32'(stolen_out), 32'h0);
    @(posedge clk_in); #1;
    chk("on1_pulse_end", 32'(voice_update_out), 32'h0);
    send(8'd64, 8'd90, 4'd0, 1'b1);
    to_result();
    chk("on2_update", 32'(voice_update_out), 32'h1);
    chk("on2_slot",   32'(update_slot_out),  32'd1);
    chk("on2_active", 32'(voice_active_out), 32'h03);
    chk("on2_note",   32'(voice_note_out[15:8]),     32'd64);
    chk("on2_vel",    32'(voice_velocity_out[15:8]), 32'd90);

    // Velocity-0 note-on acts as note-off
    do_reset();
    send(8'd60, 8'd100, 4'd0, 1'b1);
    to_result();
    send(8'd60, 8'd0, 4'd0, 1'b1);
    to_result();
    chk("v0off_update", 32'(voice_update_out), 32'h1);
    chk("v0off_slot",   32'(update_slot_out),  32'd0);
    chk("v0off_active", 32'(voice_active_out), 32'h00);
    chk("v0off_vel",    32'(voice_velocity_out[7:0]), 32'd0);
    chk("v0off_note_kept", 32'(voice_note_out[7:0]), 32'd60);

    // Same note on a different channel takes a new slot
    do_reset();
    send(8'd60, 8'd100, 4'd0, 1'b1);
    to_result();
    send(8'd60, 8'd40, 4'd1, 1'b1);
    to_result();
    chk("chan_slot",   32'(update_slot_out),  32'd1);
    chk("chan_active", 32'(voice_active_out), 32'h03);
    chk("chan_ch1",    32'(voice_channel_out[7:4]), 32'd1);

    // Retrigger of an existing voice
    do_reset();
    send(8'd60, 8'd100, 4'd0, 1'b1);
    to_result();
    send(8'd60, 8'd50, 4'd0, 1'b1);
    to_result();
    chk("retrig_update", 32'(voice_update_out), 32'h1);
    chk("retrig_slot",   32'(update_slot_out),  32'd0);
    chk("retrig_active", 32'(voice_active_out), 32'h01);
    chk("retrig_vel",    32'(voice_velocity_out[7:0]), 32'd50);
    chk("retrig_stolen", 32'(stolen_out), 32'h0);

    // Note-off with no matching voice: no update
    send(8'd72, 8'd64, 4'd3, 1'b0);
    to_result();
    chk("offmiss_update", 32'(voice_update_out), 32'h0);
    chk("offmiss_active", 32'(voice_active_out), 32'h01);

    // Fill the pool, then steal oldest twice
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(8'(60 + i), 8'd100, 4'd0, 1'b1);
      to_result();
      chk("fill_slot", 32'(update_slot_out), 32'(i));
    end
    chk("fill_active", 32'(voice_active_out), 32'hFF);
    send(8'd70, 8'd80, 4'd0, 1'b1);
    to_result();
    chk("steal1_update", 32'(voice_update_out), 32'h1);
    chk("steal1_slot",   32'(update_slot_out),  32'd0);
    chk("steal1_stolen", 32'(stolen_out),       32'h1);
    chk("steal1_note",   32'(voice_note_out[7:0]),     32'd70);
    chk("steal1_vel",    32'(voice_velocity_out[7:0]), 32'd80);
    chk("steal1_active", 32'(voice_active_out), 32'hFF);
    @(posedge clk_in); #1;
    chk("steal1_pulse_end", 32'(stolen_out), 32'h0);
    send(8'd71, 8'd80, 4'd0, 1'b1);
    to_result();
    chk("steal2_slot",   32'(update_slot_out), 32'd1);
    chk("steal2_stolen", 32'(stolen_out),      32'h1);
    chk("steal2_note",   32'(voice_note_out[15:8]), 32'd71);

    // Back-to-back valids: two processed, third dropped
    do_reset();
    @(negedge clk_in);
    velocity_in = 8'd100; channel_in = 4'd0; status_in = 1'b1;
    note_in = 8'd60; data_valid_in = 1'b1;
    @(posedge clk_in); #1;
    note_in = 8'd61;
    @(posedge clk_in); #1;
    note_in = 8'd62;
    @(posedge clk_in); #1;
    data_valid_in = 1'b0;
    chk("burst_upd1",  32'(voice_update_out), 32'h1);
    chk("burst_slot1", 32'(update_slot_out),  32'd0);
    chk("burst_drop",  32'(dropped_out),      32'h1);
    @(posedge clk_in); #1;
    chk("burst_drop_end", 32'(dropped_out),      32'h0);
    chk("burst_gap1",     32'(voice_update_out), 32'h0);
    @(posedge clk_in); #1;
    chk("burst_gap2", 32'(voice_update_out), 32'h0);
    @(posedge clk_in); #1;
    chk("burst_upd2",  32'(voice_update_out), 32'h1);
    chk("burst_slot2", 32'(update_slot_out),  32'd1);
    chk("burst_note2", 32'(voice_note_out[15:8]), 32'd61);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_in); #1;
      chk("burst_tail_upd",  32'(voice_update_out), 32'h0);
      chk("burst_tail_drop", 32'(dropped_out),      32'h0);
    end
    chk("burst_active", 32'(voice_active_out), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
